// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT core time-sharing scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Frame-length field inside a channel config word (value = length - 1)
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  // Width of a channel index; never below one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_rr_arbiter.sv
// Round-robin request picker: first set request at or after ptr, wrapping.
module fft_rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]           req,
  input  logic [ch_idx_w(NUM_CH)-1:0] ptr,
  output logic [ch_idx_w(NUM_CH)-1:0] gnt,
  output logic                        any_req
);

  localparam int CW = ch_idx_w(NUM_CH);

  logic [CW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(ptr) + k) % NUM_CH);
      if (req[idx]) begin
        gnt     = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_share_sched.sv
// Time-shares one burst FFT core between NUM_CH stream requesters, one frame at a time.
module fft_share_sched
  import fft_sched_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int CFG_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*CFG_WIDTH-1:0]    ch_cfg_data,
  input  logic [NUM_CH-1:0]              ch_s_valid,
  input  logic [NUM_CH-1:0]              ch_s_last,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0] ch_s_data,
  output logic [NUM_CH-1:0]              ch_s_ready,
  output logic                           core_cfg_valid,
  output logic [CFG_WIDTH-1:0]           core_cfg_data,
  input  logic                           core_cfg_ready,
  output logic                           core_s_valid,
  output logic                           core_s_last,
  output logic [2*DATA_WIDTH-1:0]        core_s_data,
  input  logic                           core_s_ready,
  input  logic                           core_m_valid,
  input  logic                           core_m_last,
  input  logic [2*DATA_WIDTH-1:0]        core_m_data,
  input  logic [ADDR_WIDTH:0]            core_m_addr,
  output logic                           core_m_ready,
  output logic                           m_valid,
  output logic                           m_last,
  output logic [2*DATA_WIDTH-1:0]        m_data,
  output logic [ADDR_WIDTH:0]            m_addr,
  output logic [$clog2(NUM_CH)-1:0]      m_ch,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           len_err
);

  localparam int BW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][BW-1:0]        ch_data;
  logic [NUM_CH-1:0][CFG_WIDTH-1:0] ch_cfg;

  assign ch_data = ch_s_data;
  assign ch_cfg  = ch_cfg_data;

  state_t         state;
  logic [CW-1:0]  grant;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  arb_gnt;
  logic           any_req;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] beat_cnt;
  logic           ld_hs;
  logic           dr_hs;

  fft_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (ch_s_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .any_req (any_req)
  );

  assign busy  = (state != ST_IDLE);
  assign ld_hs = core_s_valid & core_s_ready;
  assign dr_hs = core_m_valid & m_ready & (state == ST_DRAIN);

  // Config, input and result muxing; everything outside the owning state is held at 0
  always_comb begin
    core_cfg_valid = 1'b0;
    core_cfg_data  = '0;
    core_s_valid   = 1'b0;
    core_s_last    = 1'b0;
    core_s_data    = '0;
    ch_s_ready     = '0;
    core_m_ready   = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_data         = '0;
    m_addr         = '0;
    m_ch           = '0;
    case (state)
      ST_CFG: begin
        core_cfg_valid = 1'b1;
        core_cfg_data  = ch_cfg[grant];
      end
      ST_LOAD: begin
        core_s_valid      = ch_s_valid[grant];
        core_s_last       = ch_s_last[grant];
        core_s_data       = ch_data[grant];
        ch_s_ready[grant] = core_s_ready;
      end
      ST_DRAIN: begin
        m_valid      = core_m_valid;
        m_last       = core_m_last;
        m_data       = core_m_data;
        m_addr       = core_m_addr;
        m_ch         = grant;
        core_m_ready = m_ready;
      end
      default: ;
    endcase
  end

  // Frame sequencer: arbitrate, configure, load, drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      len_m1   <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= arb_gnt;
            state <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (core_cfg_ready) begin
            len_m1 <= ch_cfg[grant][LEN_MSB:LEN_LSB];
            rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ld_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (core_s_last) begin
              // compare the pre-increment count: a matching frame ends on len_m1
              len_err <= (beat_cnt != len_m1);
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dr_hs && core_m_last) begin
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_share_sched.sv
// Scoreboard bench for fft_share_sched with an echoing burst-core stub.
module tb_fft_share_sched;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int AW  = 9;
  localparam int CFW = 24;
  localparam int BW  = 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH*CFW-1:0] ch_cfg_data;
  logic [NCH-1:0]     ch_s_valid, ch_s_last, ch_s_ready;
  logic [NCH*BW-1:0]  ch_s_data;
  logic               core_cfg_valid, core_cfg_ready;
  logic [CFW-1:0]     core_cfg_data;
  logic               core_s_valid, core_s_last, core_s_ready;
  logic [BW-1:0]      core_s_data;
  logic               core_m_valid, core_m_last, core_m_ready;
  logic [BW-1:0]      core_m_data;
  logic [AW:0]        core_m_addr;
  logic               m_valid, m_last, m_ready;
  logic [BW-1:0]      m_data;
  logic [AW:0]        m_addr;
  logic [0:0]         m_ch;
  logic               busy, len_err;

  logic [CFW-1:0] cfg_w [NCH];
  logic           tv [NCH];
  logic           tl [NCH];
  logic [BW-1:0]  td [NCH];
  logic           abort = 1'b0;
  logic           tog = 1'b0;

  always_comb begin
    ch_cfg_data = '0;
    ch_s_valid  = '0;
    ch_s_last   = '0;
    ch_s_data   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_cfg_data[i*CFW +: CFW] = cfg_w[i];
      ch_s_valid[i]             = tv[i];
      ch_s_last[i]              = tl[i];
      ch_s_data[i*BW +: BW]     = td[i];
    end
  end

  fft_share_sched #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CFG_WIDTH(CFW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_cfg_data(ch_cfg_data),
    .ch_s_valid(ch_s_valid), .ch_s_last(ch_s_last), .ch_s_data(ch_s_data), .ch_s_ready(ch_s_ready),
    .core_cfg_valid(core_cfg_valid), .core_cfg_data(core_cfg_data), .core_cfg_ready(core_cfg_ready),
    .core_s_valid(core_s_valid), .core_s_last(core_s_last), .core_s_data(core_s_data),
    .core_s_ready(core_s_ready), .core_m_valid(core_m_valid), .core_m_last(core_m_last),
    .core_m_data(core_m_data), .core_m_addr(core_m_addr), .core_m_ready(core_m_ready),
    .m_valid(m_valid), .m_last(m_last), .m_data(m_data), .m_addr(m_addr), .m_ch(m_ch),
    .m_ready(m_ready), .busy(busy), .len_err(len_err)
  );

  // Core stub: cfg_ready after 3 wait cycles, stores a frame, echoes it with addr = beat index
  logic          phase;
  logic [1:0]    cfg_wait;
  logic [AW:0]   wr, rd, nlen;
  logic [BW-1:0] mem [128];

  assign core_cfg_ready = (cfg_wait == 2'd3);
  assign core_s_ready   = !phase;
  assign core_m_valid   = phase;
  assign core_m_data    = mem[rd[6:0]];
  assign core_m_addr    = rd;
  assign core_m_last    = phase && (rd == nlen - 1'b1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0; cfg_wait <= 2'd0; wr <= '0; rd <= '0; nlen <= '0;
    end else begin
      if (core_cfg_valid && !core_cfg_ready) cfg_wait <= cfg_wait + 2'd1;
      else if (core_cfg_valid) cfg_wait <= 2'd0;
      if (!phase && core_s_valid) begin
        mem[wr[6:0]] <= core_s_data;
        wr <= wr + 1'b1;
        if (core_s_last) begin
          phase <= 1'b1; nlen <= wr + 1'b1; rd <= '0;
        end
      end else if (phase && core_m_ready) begin
        rd <= rd + 1'b1;
        if (core_m_last) begin
          phase <= 1'b0; wr <= '0;
        end
      end
    end
  end

  typedef struct packed {
    logic          ch;
    logic          last;
    logic [AW:0]   addr;
    logic [BW-1:0] data;
  } exp_t;

  exp_t           exp_q[$];
  logic [CFW-1:0] cfg_q[$];
  int total = 0;
  int bad = 0;
  int lerr_cnt = 0;
  logic lerr_prev = 1'b0;
  logic last_hs_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s act=event req=none", nm);
  endtask

  function automatic logic [BW-1:0] mk(input int ch, input int fr, input int b);
    return {4'(ch), 4'(fr), 8'hA5, 8'(b), 8'(~b)};
  endfunction

  task automatic push_frame(input int ch, input int fr, input int n, input logic [CFW-1:0] cfg);
    exp_t e;
    cfg_q.push_back(cfg);
    for (int b = 0; b < n; b++) begin
      e.ch = 1'(ch); e.last = (b == n - 1); e.addr = (AW+1)'(b); e.data = mk(ch, fr, b);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int ch, input int fr, input int n);
    for (int b = 0; b < n; b++) begin
      int w;
      w = 0;
      tv[ch] = 1'b1; tl[ch] = (b == n - 1); td[ch] = mk(ch, fr, b);
      forever begin
        @(negedge clk);
        if (abort) begin tv[ch] = 1'b0; tl[ch] = 1'b0; return; end
        if (ch_s_ready[ch]) break;
        if (++w > 3000) begin fail("drv_timeout"); tv[ch] = 1'b0; tl[ch] = 1'b0; return; end
      end
      @(posedge clk); #1;
    end
    tv[ch] = 1'b0; tl[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk); w++;
    end while ((busy || exp_q.size() != 0 || cfg_q.size() != 0) && w < 3000);
    if (w >= 3000) fail("idle_timeout");
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {ch_s_ready, core_cfg_valid, core_s_valid, core_s_last, core_m_ready,
             m_valid, m_last, busy, len_err}, 0);
    chk({nm, "_mch"}, m_ch, 0);
  endtask

  // Monitor: config stability, result scoreboard, ready exclusivity, len_err pulses
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (core_cfg_valid) begin
        if (cfg_q.size() == 0) fail("cfg_unexpected");
        else begin
          chk("cfg_data", core_cfg_data, cfg_q[0]);
          if (core_cfg_ready) void'(cfg_q.pop_front());
        end
      end
      if (m_valid) chk("core_m_ready", core_m_ready, m_ready);
      if (last_hs_d) chk("busy_after_last", busy, 0);
      last_hs_d = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail("m_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_ch", m_ch, e.ch);
          chk("m_addr", m_addr, e.addr);
          chk("m_last", m_last, e.last);
          last_hs_d = m_last;
        end
      end
      if (ch_s_ready != '0) chk("ready_onehot", ch_s_ready[0] & ch_s_ready[1], 0);
      if (len_err && lerr_prev) fail("len_err_wide");
      if (len_err) lerr_cnt++;
      lerr_prev = len_err;
    end else begin
      lerr_prev = 1'b0;
      last_hs_d = 1'b0;
    end
  end

  // Downstream ready: steady 1, or alternating each cycle when tog is set
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = tog ? ~m_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < NCH; i++) begin tv[i] = 1'b0; tl[i] = 1'b0; td[i] = '0; end
    cfg_w[0] = 24'hC0_003F;
    cfg_w[1] = 24'hC1_003F;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // single 64-beat ch0 frame, matching length
    base = lerr_cnt;
    push_frame(0, 0, 64, 24'hC0_003F);
    send_frame(0, 0, 64);
    wait_idle();
    chk("t1_len_err", lerr_cnt - base, 0);

    // both channels busy: ch0 starts first, then strict alternation 0,1,0,1,...
    cfg_w[0] = 24'hC0_0007;
    cfg_w[1] = 24'hC1_0007;
    for (int f = 1; f <= 4; f++) begin
      push_frame(0, f, 8, 24'hC0_0007);
      push_frame(1, f, 8, 24'hC1_0007);
    end
    fork
      begin for (int f = 1; f <= 4; f++) send_frame(0, f, 8); end
      begin repeat (2) @(posedge clk); #1; for (int f = 1; f <= 4; f++) send_frame(1, f, 8); end
    join
    wait_idle();

    // alternating downstream ready during drain
    tog = 1'b1;
    push_frame(1, 5, 8, 24'hC1_0007);
    send_frame(1, 5, 8);
    wait_idle();
    tog = 1'b0;

    // short ch1 frame (33 beats) against len_m1 = 63
    cfg_w[1] = 24'hC1_003F;
    base = lerr_cnt;
    push_frame(1, 6, 33, 24'hC1_003F);
    send_frame(1, 6, 33);
    wait_idle();
    chk("t4_len_err", lerr_cnt - base, 1);

    // ch0 config changed during drain applies only to the next ch0 frame
    cfg_w[0] = 24'h11_0007;
    push_frame(0, 7, 8, 24'h11_0007);
    fork
      send_frame(0, 7, 8);
      begin
        int w;
        w = 0;
        do begin @(negedge clk); w++; end while (!m_valid && w < 3000);
        if (w >= 3000) fail("drain_timeout");
        cfg_w[0] = 24'h5A_0007;
      end
    join
    wait_idle();
    push_frame(0, 8, 8, 24'h5A_0007);
    send_frame(0, 8, 8);
    wait_idle();

    // reset in the middle of a ch0 load
    cfg_w[0] = 24'hC0_003F;
    cfg_q.push_back(24'hC0_003F);
    fork
      send_frame(0, 9, 64);
      begin
        int acc, w;
        acc = 0; w = 0;
        while (acc < 10 && w < 3000) begin
          @(negedge clk); w++;
          if (tv[0] && ch_s_ready[0]) acc++;
        end
        if (acc < 10) fail("load_timeout");
        @(posedge clk); #2;
        rst_n = 1'b0; abort = 1'b1;
        #1 chk_zero("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        abort = 1'b0;
      end
    join
    // round-robin pointer back at 0: ch0 wins a simultaneous request
    cfg_w[0] = 24'hC0_0007;
    cfg_w[1] = 24'hC1_0007;
    push_frame(0, 10, 8, 24'hC0_0007);
    push_frame(1, 10, 8, 24'hC1_0007);
    fork
      send_frame(0, 10, 8);
      send_frame(1, 10, 8);
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_share_sched.md
Name: fft_share_sched

Overview:
- Time-shares one burst FFT/IFFT core (fft_top) between NUM_CH independent AXI-stream requesters.
- Per frame: picks a requester round-robin, issues that channel's config word to the core, streams the channel's frame in, then drains the core's result to a common output tagged with the owning channel.
- Sits between the channel front-ends and the fft_top instance; exactly one frame is in the core at a time.

Parameters:
- NUM_CH, 2, number of requesters (2..4)
- DATA_WIDTH, 16, per-component sample width; a beat is {im,re}, 2*DATA_WIDTH bits
- ADDR_WIDTH, 9, core index width; m_addr is ADDR_WIDTH+1 bits
- CFG_WIDTH, 24, core config word width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ch_cfg_data  in  NUM_CH*CFG_WIDTH  per-channel static config; bits[15:0] = frame length minus 1; slice i belongs to channel i
- ch_s_valid  in  NUM_CH  per-channel input valid
- ch_s_last  in  NUM_CH  per-channel last beat of frame
- ch_s_data  in  NUM_CH*2*DATA_WIDTH  per-channel input beat
- ch_s_ready  out  NUM_CH  per-channel ready
- core_cfg_valid  out  1  config to core
- core_cfg_data  out  CFG_WIDTH  config word
- core_cfg_ready  in  1  core config ready
- core_s_valid / core_s_last / core_s_data  out  1/1/2*DATA_WIDTH  input stream to core
- core_s_ready  in  1  core input ready
- core_m_valid / core_m_last / core_m_data / core_m_addr  in  1/1/2*DATA_WIDTH/ADDR_WIDTH+1  core result stream
- core_m_ready  out  1  core result ready
- m_valid / m_last / m_data / m_addr  out  1/1/2*DATA_WIDTH/ADDR_WIDTH+1  shared result stream
- m_ch  out  $clog2(NUM_CH)  owning channel of current result beat
- m_ready  in  1  downstream ready
- busy  out  1  high in every state except IDLE
- len_err  out  1  one-cycle pulse on a length-mismatch frame

Behaviour:
- Reset: FSM = IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0.
  - Outputs during reset: all ready/valid/last outputs 0, busy 0, len_err 0, m_ch 0.
  - Reset mid-frame abandons the frame silently; no flush.
- FSM states: IDLE -> CFG -> LOAD -> DRAIN -> IDLE.
- IDLE:
  - Requests = ch_s_valid.
  - If any request is set, register grant = first requesting index starting at rr_ptr, wrapping modulo NUM_CH. Go to CFG next cycle (1-cycle arbitration latency).
  - If no request, stay in IDLE.
- CFG:
  - core_cfg_valid = 1, core_cfg_data = ch_cfg_data slice[grant].
  - Hold both stable until core_cfg_ready, then go to LOAD.
  - Latch len_m1 = config bits[15:0].
  - Set rr_ptr = grant+1, wrapping.
- LOAD:
  - Combinational pass-through for the granted channel only: core_s_valid/last/data = ch_s_*[grant], ch_s_ready[grant] = core_s_ready.
  - All other ch_s_ready = 0; core_s_valid = 0 in every other state.
  - beat_cnt increments on each core_s_valid & core_s_ready.
  - On the last-accepted beat: if beat_cnt != len_m1 (count before increment), pulse len_err the next cycle. The frame still completes. Go to DRAIN.
  - A beat with count == len_m1 but no last is not flagged; the channel keeps loading until last.
- DRAIN:
  - m_valid/last/data/addr = core_m_*, core_m_ready = m_ready (no added latency). m_ch = grant.
  - core_m_ready = 0 outside DRAIN.
  - On core_m_valid & m_ready & core_m_last, go to IDLE and clear beat_cnt.
  - New requests wait; a next frame is granted no earlier than 1 cycle after the last output beat.
- Fairness:
  - A channel asserting ch_s_valid continuously is granted within NUM_CH frames.
  - A channel that drops valid after its grant keeps the grant; no timeout.
- Config: ch_cfg_data is sampled only in CFG. Changes during LOAD/DRAIN take effect on that channel's next grant.

Decomposition:
- Shared package fft_sched_pkg holds:
  - state encoding constants (IDLE/CFG/LOAD/DRAIN);
  - CFG length-field bounds (LEN_LSB = 0, LEN_MSB = 15);
  - a channel-index width function.
- One sub-module: fft_rr_arbiter (NUM_CH-wide request vector + rr_ptr -> grant index + any_req; purely combinational). Reused by future multi-requester blocks.
- Stream muxing and the FSM stay in fft_share_sched.

Test Plan:
- Single channel 0, NUM_CH=2, cfg len_m1=63, 64-beat frame, core stub with 3-cycle cfg_ready delay:
  - core_cfg_data equals ch0 cfg, held 3 cycles.
  - 64 beats pass bit-exact; len_err stays 0.
  - m_ch=0 on all 64 result beats; busy drops 1 cycle after the last output beat.
- Both channels valid continuously for 4 frames each -> grant order 0,1,0,1,...; ch_s_ready[1]=0 for the whole of each ch0 LOAD.
- m_ready toggling 1-0-1 each cycle during DRAIN -> core_m_ready mirrors m_ready; every output beat is delivered exactly once, in order.
- ch1 frame with last on beat 32 while len_m1=63 -> len_err pulses exactly once; FSM still reaches DRAIN and later IDLE.
- rst_n asserted mid-LOAD at beat 10, released later -> all outputs 0 immediately; after release, grant restarts at channel 0 from IDLE.
- ch0 cfg changed during DRAIN -> that frame is unaffected; the next ch0 CFG issues the new word.
